display_value_formatter: RTL and testbench

Converts a 16-bit value into the four 4-bit digit codes consumed by the Basys3 seven-segment scan driver. It samples the value at a human-readable rate and presents it as hex or, optionally, as decimal via a sequential double-dabble converter. It sits between the CPU debug/observation mux and the seven-segment driver in the FPGA wrapper. Updates to its `dig` output are atomic, so the display never shows a half-converted value.

---
 rtl/display_value_formatter.sv | 87 ++++++++
 tb/tb_display_value_formatter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/display_value_formatter.sv
// display_value_formatter: samples a 16-bit value at SAMPLE_CYCLES intervals and presents it as four digit codes.
// Decimal display through a sequential double-dabble converter is compiled in only when DISPLAY_DECIMAL_EN is defined.
module display_value_formatter #(
  parameter int VALUE_W = 16,
  parameter int SAMPLE_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        dec_mode,
  input  logic        freeze,
  output logic [3:0]  dig [3:0],
  output logic        busy,
  output logic        overflow
);
  localparam int CW = $clog2(SAMPLE_CYCLES);
  if (VALUE_W != 16) begin : g_bad_width
    $error("display_value_formatter: VALUE_W must be 16");
  end
  if (SAMPLE_CYCLES < VALUE_W + 4) begin : g_bad_period
    $error("display_value_formatter: SAMPLE_CYCLES must be at least VALUE_W+4");
  end
  typedef enum logic [1:0] {IDLE, HEX, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [15:0] val_r;
  logic tick, cap;
  assign tick = cnt == CW'(SAMPLE_CYCLES - 1);
  assign cap = tick && !freeze && state == IDLE;
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_nx;
`ifdef DISPLAY_DECIMAL_EN
  logic mode_r;
  logic [19:0] bcd, adj;
  logic [4:0] it;
  logic ovf_nx;
  always_comb state_nx = cap ? (dec_mode ? SHIFT : HEX) : state == SHIFT ? (it == 5'd15 ? DONE : SHIFT) : IDLE;
  always_comb busy = mode_r && (state == SHIFT || state == DONE);
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++) adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign ovf_nx = |bcd[19:16];
  always_ff @(posedge clk)
    if (!reset_n) begin
      mode_r <= 1'b0;
      bcd <= '0;
      it <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap) begin
        mode_r <= dec_mode;
        bcd <= '0;
        it <= '0;
      end
      if (state == SHIFT) begin
        bcd <= {adj[18:0], val_r[15]};
        it <= it + 5'd1;
      end
      if (state == HEX || state == DONE) overflow <= state == DONE && ovf_nx;
    end
`else
  logic unused_dec;
  assign unused_dec = dec_mode;
  always_comb state_nx = cap ? HEX : IDLE;
  assign busy = 1'b0;
  assign overflow = 1'b0;
`endif
  // All four digits are written on one edge so the scan driver never sees a mixed value.
  always_ff @(posedge clk)
    if (!reset_n) begin
      cnt <= '0;
      val_r <= '0;
      dig <= '{default: 4'h0};
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (cap) val_r <= value;
`ifdef DISPLAY_DECIMAL_EN
      if (state == SHIFT) val_r <= val_r << 1;
`endif
      for (int i = 0; i < 4; i++) begin
        if (state == HEX) dig[i] <= val_r[4*i +: 4];
`ifdef DISPLAY_DECIMAL_EN
        if (state == DONE) dig[i] <= ovf_nx ? 4'hE : bcd[4*i +: 4];
`endif
      end
    end
endmodule

// File: tb/tb_display_value_formatter.sv
// tb_display_value_formatter: randomized and directed checks of display_value_formatter against a latency/arithmetic model.
module tb_display_value_formatter;
  localparam int SC = 32;
`ifdef DISPLAY_DECIMAL_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  logic clk, reset_n, dec_mode, freeze, busy, overflow;
  logic [15:0] value, dig_p;
  logic [3:0] dig [3:0];
  int n_tests, n_fail, mcnt, pend;
  bit p_dec;
  logic [15:0] e_dig, n_dig;
  logic e_ovf, n_ovf;

  display_value_formatter #(.VALUE_W(16), .SAMPLE_CYCLES(SC)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dec_mode(dec_mode),
    .freeze(freeze), .dig(dig), .busy(busy), .overflow(overflow)
  );
  assign dig_p = {dig[3], dig[2], dig[1], dig[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Display result for a sampled value: {overflow, four digit codes}.
  function automatic logic [16:0] fmt(input logic [15:0] v, input logic dm);
    if (dm && v > 16'd9999) return {1'b1, 16'hEEEE};
    if (dm) return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return {1'b0, v};
  endfunction

  // Advance one clock edge, update the model from the pre-edge inputs, then compare.
  task automatic step();
    logic [15:0] v;
    logic dm, fz, rn;
    logic [16:0] f;
    v = value;
    dm = DEC && dec_mode;
    fz = freeze;
    rn = reset_n;
    @(posedge clk);
    #1;
    if (!rn) begin
      mcnt = 0;
      pend = 0;
      p_dec = 0;
      e_dig = 16'h0;
      e_ovf = 1'b0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          e_dig = n_dig;
          e_ovf = n_ovf;
        end
      end else if (mcnt == SC - 1 && !fz) begin
        f = fmt(v, dm);
        n_dig = f[15:0];
        n_ovf = f[16];
        pend = dm ? 17 : 1;
        p_dec = dm;
      end
      mcnt = (mcnt + 1) % SC;
    end
    check("dig", dig_p, e_dig);
    check("busy", {15'b0, busy}, {15'b0, p_dec && pend > 0});
    check("overflow", {15'b0, overflow}, {15'b0, e_ovf});
  endtask

  // Hold inputs through the next sample tick and let any conversion finish.
  task automatic run_tick(input logic [15:0] v, input logic dm, input logic fz);
    value = v;
    dec_mode = dm;
    freeze = fz;
    for (int i = 0; i < 2 * SC; i++) begin
      step();
      if (mcnt == 0) break;
    end
    repeat (18) step();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mcnt = 0; pend = 0; p_dec = 0;
    e_dig = 16'h0; e_ovf = 1'b0; n_dig = 16'h0; n_ovf = 1'b0;
    reset_n = 1'b0; value = 16'h0; dec_mode = 1'b0; freeze = 1'b0;
    repeat (3) step();
    check("reset_dig", dig_p, 16'h0);
    reset_n = 1'b1;
    value = 16'hABCD;
    repeat (32) step();
    check("first_cap_pre", dig_p, 16'h0);
    step();
    check("first_cap", dig_p, 16'hABCD);
    run_tick(16'hBEEF, 1'b0, 1'b0);
    check("hex_beef", dig_p, 16'hBEEF);
    check("hex_beef_ovf", {15'b0, overflow}, 16'h0);
    run_tick(16'd1234, 1'b1, 1'b0);
    check("dec_1234", dig_p, DEC ? 16'h1234 : 16'h04D2);
    run_tick(16'd65535, 1'b1, 1'b0);
    check("dec_65535", dig_p, DEC ? 16'hEEEE : 16'hFFFF);
    check("dec_65535_ovf", {15'b0, overflow}, {15'b0, DEC});
    run_tick(16'd9999, 1'b1, 1'b0);
    check("dec_9999", dig_p, DEC ? 16'h9999 : 16'h270F);
    check("dec_9999_ovf", {15'b0, overflow}, 16'h0);
    run_tick(16'd10000, 1'b1, 1'b0);
    check("dec_10000", dig_p, DEC ? 16'hEEEE : 16'h2710);
    run_tick(16'h1111, 1'b0, 1'b0);
    check("frz_base", dig_p, 16'h1111);
    repeat (3) begin
      run_tick(16'h2222, 1'b0, 1'b1);
      check("frz_hold", dig_p, 16'h1111);
    end
    run_tick(16'h2222, 1'b0, 1'b0);
    check("frz_release", dig_p, 16'h2222);
    value = 16'd4321;
    dec_mode = 1'b1;
    for (int i = 0; i < 2 * SC; i++) begin
      step();
      if (mcnt == 0) break;
    end
    repeat (4) step();
    reset_n = 1'b0;
    step();
    check("midrst_busy", {15'b0, busy}, 16'h0);
    check("midrst_dig", dig_p, 16'h0);
    reset_n = 1'b1;
    repeat (SC - 1) step();
    check("midrst_no_stale", dig_p, 16'h0);
    for (int i = 0; i < 1200; i++) begin
      value = $urandom_range(0, 1) ? 16'($urandom_range(0, 10001)) : 16'($urandom);
      dec_mode = 1'($urandom_range(0, 1));
      freeze = $urandom_range(0, 5) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
